// File: rtl/clas_bias_streamer.sv
// clas_bias_streamer
//    Holds NUM_SETS sets of NUM_CH signed classifier biases and streams one
//    selected set, one bias per beat, to the classifier accumulator stage.
//
//    Optional feature macro: CLAS_BS_WR_EN
//       defined   : run-time write port, table is a register array that
//                   reloads its defaults on reset
//       undefined : no write port, table is a constant ROM
//
//    Ports
//       clk, rst                     clock, synchronous active-high reset
//       req_valid/req_set/req_ready  set-select request handshake
//       bias_valid/bias_ready        output beat handshake
//       bias_data                    signed bias of the current beat
//       bias_ch                      channel index of the current beat
//       bias_last                    final beat of the set
//       bias_err                     stream belongs to an out-of-range request
//       wr_en/wr_set/wr_ch/wr_data   table write (CLAS_BS_WR_EN only)
//
//    state    | meaning
//    ---------+---------------------------------------------------
//    S_IDLE   | waiting for a request, req_ready high
//    S_STREAM | presenting beats of the latched set, bias_valid high

module clas_bias_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_CH     = 6,
   parameter int NUM_SETS   = 4,
   localparam int CH_W      = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   input  logic [ADDR_WIDTH-1:0]        req_set,
   output logic                         req_ready,
   output logic                         bias_valid,
   input  logic                         bias_ready,
   output logic signed [DATA_WIDTH-1:0] bias_data,
   output logic [CH_W-1:0]              bias_ch,
   output logic                         bias_last,
   output logic                         bias_err
`ifdef CLAS_BS_WR_EN
   ,
   input  logic                         wr_en,
   input  logic [ADDR_WIDTH-1:0]        wr_set,
   input  logic [CH_W-1:0]              wr_ch,
   input  logic signed [DATA_WIDTH-1:0] wr_data
`endif
);

   localparam int SET_W = $clog2(NUM_SETS);
   // Wide enough that neither the address nor NUM_SETS gets truncated.
   localparam int CMP_W = ((ADDR_WIDTH > 32) ? ADDR_WIDTH : 32) + 1;

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t                         state;
   logic [SET_W-1:0]               set_q;
   logic [CH_W-1:0]                ch_q;
   logic                           err_q;
   logic                           ch_last;
   logic                           req_oor;
   logic signed [DATA_WIDTH-1:0]   tbl_rd;

   // Default contents: set 1 carries the trained biases, all else is zero.
   function automatic logic signed [DATA_WIDTH-1:0] def_val(input int s, input int c);
      int v;
      v = 0;
      if (s == 1) begin
         case (c)
            0:       v = 4;
            1:       v = -1;
            3:       v = -7;
            5:       v = -6;
            default: v = 0;
         endcase
      end
      return DATA_WIDTH'(v);
   endfunction

   assign req_oor = (CMP_W'(req_set) >= CMP_W'(NUM_SETS));
   assign ch_last = (ch_q == CH_W'(NUM_CH - 1));

`ifdef CLAS_BS_WR_EN
   logic signed [DATA_WIDTH-1:0] tbl [NUM_SETS][NUM_CH];
   logic                         wr_ok;

   assign wr_ok = (CMP_W'(wr_set) < CMP_W'(NUM_SETS)) && (int'(wr_ch) < NUM_CH);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int c = 0; c < NUM_CH; c++) begin
               tbl[s][c] <= def_val(s, c);
            end
         end
      end else if (wr_en && wr_ok) begin
         tbl[SET_W'(wr_set)][wr_ch] <= wr_data;
      end
   end

   assign tbl_rd = tbl[set_q][ch_q];
`else
   assign tbl_rd = def_val(int'(set_q), int'(ch_q));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         set_q      <= '0;
         ch_q       <= '0;
         err_q      <= 1'b0;
         req_ready  <= 1'b1;
         bias_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  state      <= S_STREAM;
                  // An out-of-range set latches index 0 so the table read
                  // always stays inside the array; err_q forces the data to 0.
                  set_q      <= req_oor ? '0 : SET_W'(req_set);
                  err_q      <= req_oor;
                  ch_q       <= '0;
                  req_ready  <= 1'b0;
                  bias_valid <= 1'b1;
               end
            end
            S_STREAM: begin
               if (bias_ready) begin
                  if (ch_last) begin
                     state      <= S_IDLE;
                     ch_q       <= '0;
                     err_q      <= 1'b0;
                     req_ready  <= 1'b1;
                     bias_valid <= 1'b0;
                  end else begin
                     ch_q <= ch_q + CH_W'(1);
                  end
               end
            end
            default: begin
               state      <= S_IDLE;
               req_ready  <= 1'b1;
               bias_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bias_data = err_q ? '0 : tbl_rd;
   assign bias_ch   = ch_q;
   assign bias_last = bias_valid && ch_last;
   assign bias_err  = err_q;

endmodule

// File: doc/clas_bias_streamer.md
# clas_bias_streamer

Parametrised classifier-bias store and streamer for the ECG classifier datapath. Holds `NUM_SETS` bias sets of `NUM_CH` signed entries, accepts a set-select request over a valid/ready handshake, and emits the selected set one bias per beat on a valid/ready output stream with channel index and last flag. It feeds the classifier accumulator stage.

## Interface
- `DATA_WIDTH`, default 8: signed bias width.
- `ADDR_WIDTH`, default 8: set-select width.
- `NUM_CH`, default 6: biases per set. Must be at least 2.
- `NUM_SETS`, default 4: stored sets. Must be at least 2.
- `CH_W`, derived: `$clog2(NUM_CH)`.
- `clk  in  1`: clock. This block has one clock.
- `rst  in  1`: reset. Synchronous, active-high.
- `req_valid  in  1`: set-select request.
- `req_set  in  ADDR_WIDTH`: requested set index.
- `req_ready  out  1`: request can be accepted.
- `bias_valid  out  1`: output beat valid.
- `bias_ready  in  1`: downstream accepts the beat.
- `bias_data  out  DATA_WIDTH`: signed bias value.
- `bias_ch  out  CH_W`: channel index of the beat.
- `bias_last  out  1`: final beat of the set.
- `bias_err  out  1`: the current stream belongs to an out-of-range request.
- `wr_en  in  1`: table write strobe. Only present with `CLAS_BS_WR_EN`.
- `wr_set  in  ADDR_WIDTH`: write set index. Only present with `CLAS_BS_WR_EN`.
- `wr_ch  in  CH_W`: write channel index. Only present with `CLAS_BS_WR_EN`.
- `wr_data  in  DATA_WIDTH`: write value. Only present with `CLAS_BS_WR_EN`.

## Operation
- Table contents after reset:
  - Set 1 = {4, -1, 0, -7, 0, -6} for channels 0..5, sign-extended or truncated to `DATA_WIDTH`. Channels at or above 6 are 0.
  - All other sets are 0.
- FSM has two states, IDLE and STREAM.
  - IDLE: `req_ready`=1. When `req_valid` is high, latch `req_set`, clear the channel counter to 0, and go to STREAM.
  - STREAM: `req_ready`=0 and `bias_valid`=1. `bias_data` = table[set][ch].
  - On each `bias_valid && bias_ready`: if ch = `NUM_CH-1`, go to IDLE; otherwise ch = ch+1.
- `bias_last` = (ch == `NUM_CH-1`) while `bias_valid` is high, and 0 otherwise.
- `bias_ch` = ch.
- Out-of-range request (`req_set` >= `NUM_SETS`, compared on the full `ADDR_WIDTH` value):
  - The request is accepted and the stream runs `NUM_CH` beats with `bias_data`=0.
  - `bias_err`=1 for the whole stream.
  - No other side effects.
- `bias_data` is driven combinationally from the table at the current ch, so it is always live table data.
- `bias_data`, `bias_ch` and `bias_err` hold stable while `bias_valid` is high and `bias_ready` is low, unless a write hits the displayed entry (see Configuration).
- `req_valid` while in STREAM is ignored; the requester must hold it until `req_ready`.
- `bias_ready` while `bias_valid`=0 has no effect.

## Timing
- Reset values: `req_ready`=1, `bias_valid`=0, `bias_data`=0, `bias_ch`=0, `bias_last`=0, `bias_err`=0. State is IDLE, the table holds its reset contents, and the latched set is 0.
- Request accepted in cycle N: the first beat is valid in cycle N+1.
- Each handshake advances one beat in the next cycle.
- Last handshake in cycle M: `bias_valid`=0 and `req_ready`=1 in cycle M+1.
- Minimum period is `NUM_CH`+1 cycles per set with `bias_ready` held high.
- `rst` asserted mid-stream: the stream aborts and the next cycle shows the reset values. The table reloads its defaults, and any partially streamed set is not resumed.

## Configuration
- `CLAS_BS_WR_EN` defined:
  - The write port exists. `wr_en` writes `wr_data` to table[`wr_set`][`wr_ch`] at the clock edge.
  - Writes with `wr_set` >= `NUM_SETS` or `wr_ch` >= `NUM_CH` are dropped.
  - A write is visible on `bias_data` from the cycle after the edge. A beat handshaken in the same cycle as the write carries the old value.
  - Writes are allowed in any state.
  - `rst` has priority over `wr_en`.
- `CLAS_BS_WR_EN` undefined: the write ports are absent and the table is a constant ROM holding the reset contents.

## Test plan
- Reset, then req_set=1 with `bias_ready`=1 held → beats 4, -1, 0, -7, 0, -6 with `bias_ch` 0..5 in cycles N+1..N+6. `bias_last` only on the beat 6 cycle, `bias_err`=0, and `req_ready`=1 in N+7.
- Set 1 with `bias_ready` toggling 1,0,0,1,... → no beat is dropped or duplicated, outputs hold during stalls, and the sequence is the same as the previous scenario.
- req_set=8'hFF → 6 beats of 0 with `bias_err`=1. A following req_set=0 returns 6 zeros with `bias_err`=0.
- `req_valid` pulsed during STREAM with req_set=2 → ignored. The stream finishes with set 1 data and no second stream starts.
- `rst` asserted on beat 3 → the next cycle `bias_valid`=0 and `req_ready`=1. A new request for set 1 restarts from ch 0 with the default values.
- Write scenarios:
  - `CLAS_BS_WR_EN` defined: write set 2 ch 3 = -128, then request set 2 → beats 0, 0, 0, -128, 0, 0. A write to set 1 ch 5 = 9 while beat 2 of set 1 is stalled makes beat 5 = 9.
  - `CLAS_BS_WR_EN` undefined: the write ports do not exist and set 2 streams 0 on all 6 beats.
